// File: rtl/timing_mem_loader.sv
// rtl/timing_mem_loader.sv - streams host words into the timing core's timestamp/active-pixel memories
module timing_mem_loader (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        update_mem_i,
    input  logic [9:0]  points_per_line_i,
    input  logic [2:0]  mem_last_i,
    input  logic        abort_i,
    input  logic [16:0] s_data_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    output logic        load_req_o,
    output logic [8:0]  waddr_o,
    output logic [16:0] wdata_o,
    output logic        we_o,
    output logic [2:0]  memory_selector_o,
    output logic        mem_updated_o,
    output logic        busy_o,
    output logic        missed_o
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_ACK} state_t;

    state_t      state, state_nxt;
    logic        upd_prev;
    logic        upd_edge;
    logic [8:0]  last_addr, addr_cnt;
    logic [2:0]  last_sel, sel_cnt;
    logic        beat;
    logic        addr_wrap;
    logic        last_beat;

    assign upd_edge  = update_mem_i & ~upd_prev;
    assign beat      = (state == S_LOAD) & s_valid_i & ~abort_i;
    assign addr_wrap = (addr_cnt == last_addr);
    assign last_beat = addr_wrap & (sel_cnt == last_sel);

    always_comb begin
        state_nxt     = state;
        s_ready_o     = 1'b0;
        load_req_o    = 1'b0;
        mem_updated_o = 1'b0;
        busy_o        = 1'b1;
        case (state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (upd_edge) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                load_req_o = 1'b1;
                s_ready_o  = ~abort_i;
                if (abort_i)                state_nxt = S_IDLE;
                else if (beat && last_beat) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                state_nxt = abort_i ? S_IDLE : S_ACK;
            end
            S_ACK: begin
                // An abort landing on the ack cycle suppresses the acknowledge.
                mem_updated_o = ~abort_i;
                state_nxt     = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state             <= S_IDLE;
            upd_prev          <= 1'b0;
            last_addr         <= 9'd0;
            last_sel          <= 3'd0;
            addr_cnt          <= 9'd0;
            sel_cnt           <= 3'd0;
            waddr_o           <= 9'd0;
            wdata_o           <= 17'd0;
            we_o              <= 1'b0;
            memory_selector_o <= 3'd0;
            missed_o          <= 1'b0;
        end else begin
            state    <= state_nxt;
            upd_prev <= update_mem_i;
            we_o     <= beat;
            if (state == S_IDLE && upd_edge) begin
                last_addr <= (points_per_line_i > 10'd511) ? 9'd511 : points_per_line_i[8:0];
                last_sel  <= mem_last_i;
                addr_cnt  <= 9'd0;
                sel_cnt   <= 3'd0;
                missed_o  <= 1'b0;
            end else if (state != S_IDLE && upd_edge) begin
                missed_o  <= 1'b1;
            end
            if (beat) begin
                waddr_o           <= addr_cnt;
                wdata_o           <= s_data_i;
                memory_selector_o <= sel_cnt;
                if (addr_wrap) begin
                    addr_cnt <= 9'd0;
                    sel_cnt  <= sel_cnt + 3'd1;
                end else begin
                    addr_cnt <= addr_cnt + 9'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_timing_mem_loader.sv
// tb/tb_timing_mem_loader.sv - directed table-driven bench for timing_mem_loader
module tb_timing_mem_loader;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        update_mem_i = 1'b0;
    logic [9:0]  points_per_line_i = 10'd0;
    logic [2:0]  mem_last_i = 3'd0;
    logic        abort_i = 1'b0;
    logic [16:0] s_data_i = 17'd0;
    logic        s_valid_i = 1'b0;
    logic        s_ready_o, load_req_o, we_o, mem_updated_o, busy_o, missed_o;
    logic [8:0]  waddr_o;
    logic [16:0] wdata_o;
    logic [2:0]  memory_selector_o;

    timing_mem_loader dut (
        .clk_i(clk), .rst_i(rst_i), .update_mem_i(update_mem_i),
        .points_per_line_i(points_per_line_i), .mem_last_i(mem_last_i),
        .abort_i(abort_i), .s_data_i(s_data_i), .s_valid_i(s_valid_i),
        .s_ready_o(s_ready_o), .load_req_o(load_req_o), .waddr_o(waddr_o),
        .wdata_o(wdata_o), .we_o(we_o), .memory_selector_o(memory_selector_o),
        .mem_updated_o(mem_updated_o), .busy_o(busy_o), .missed_o(missed_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int ack_cnt  = 0;
    int ack_cyc  = 0;
    int first_acc, last_acc;
    logic [28:0] wq[$];

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (we_o) wq.push_back({memory_selector_o, waddr_o, wdata_o});
        if (mem_updated_o) begin
            ack_cnt = ack_cnt + 1;
            ack_cyc = cyc;
        end
    end

    typedef struct {
        int          ppl;
        int          ml;
        bit          gap;
        logic [16:0] base;
        int          n;
        int          ela;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic check_writes(input string name, input int n, input int ela, input logic [16:0] base);
        int bad = 0;
        for (int i = 0; i < n && i < wq.size(); i++) begin
            logic [2:0]  s = 3'(i / (ela + 1));
            logic [8:0]  a = 9'(i % (ela + 1));
            logic [16:0] d = base + 17'(i);
            if (wq[i] !== {s, a, d}) begin
                if (bad == 0)
                    $display("write %0d of %s: got 0x%0h expected 0x%0h", i, name, wq[i], {s, a, d});
                bad++;
            end
        end
        chk({name, "_wcount"}, wq.size(), n);
        chk({name, "_wseq"}, bad, 0);
    endtask

    task automatic pulse_update(input int ppl, input int ml);
        @(negedge clk);
        points_per_line_i = 10'(ppl);
        mem_last_i        = 3'(ml);
        update_mem_i      = 1'b1;
        @(posedge clk);
        #1 update_mem_i = 1'b0;
        points_per_line_i = 10'h3ff - 10'(ppl);
        mem_last_i        = ~3'(ml);
    endtask

    task automatic send_beats(input string name, input int n, input bit gap,
                              input logic [16:0] base, input int missed_at);
        int  sent   = 0;
        bit  pulsed = 0;
        for (int k = 0; k < n * 4 + 20 && sent < n; k++) begin
            @(negedge clk);
            s_valid_i = gap ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            s_data_i  = base + 17'(sent);
            if (sent == missed_at && !pulsed) begin
                update_mem_i = 1'b1;
                pulsed = 1;
            end else begin
                update_mem_i = 1'b0;
            end
            #1;
            if (s_valid_i && s_ready_o) begin
                sent++;
                if (sent == 1) first_acc = cyc;
                last_acc = cyc;
            end
        end
        @(posedge clk);
        #1 s_valid_i = 1'b0;
        update_mem_i = 1'b0;
        chk({name, "_accepted"}, sent, n);
    endtask

    task automatic wait_ack(input string name, input int ack0);
        int k = 0;
        while (ack_cnt == ack0 && k < 10) begin
            @(negedge clk);
            #1 k++;
        end
        chk({name, "_ack_seen"}, ack_cnt - ack0, 1);
        chk({name, "_ack_lat"}, ack_cyc - last_acc, 2);
        @(negedge clk);
        #1 chk({name, "_idle_after"}, busy_o, 1'b0);
        chk({name, "_single_ack"}, ack_cnt - ack0, 1);
    endtask

    initial begin
        int ack0;
        vecs[0] = '{ppl: 3,   ml: 1, gap: 0, base: 17'h00010, n: 8,   ela: 3};
        vecs[1] = '{ppl: 3,   ml: 1, gap: 1, base: 17'h00010, n: 8,   ela: 3};
        vecs[2] = '{ppl: 600, ml: 0, gap: 0, base: 17'h00100, n: 512, ela: 511};
        vecs[3] = '{ppl: 0,   ml: 7, gap: 0, base: 17'h1F000, n: 8,   ela: 0};
        vecs[4] = '{ppl: 5,   ml: 2, gap: 1, base: 17'h1FFFE, n: 18,  ela: 5};

        repeat (3) @(posedge clk);
        #1 chk("reset_outputs",
               {11'd0, we_o, waddr_o, wdata_o, memory_selector_o, mem_updated_o,
                busy_o, missed_o, s_ready_o, load_req_o}, 32'd0);
        rst_i = 1'b0;
        @(posedge clk);
        #1 chk("idle_after_reset", {busy_o, s_ready_o, load_req_o}, 3'b000);

        for (int v = 0; v < 5; v++) begin
            string nm = $sformatf("vec%0d", v);
            wq.delete();
            ack0 = ack_cnt;
            pulse_update(vecs[v].ppl, vecs[v].ml);
            chk({nm, "_load_req"}, {load_req_o, s_ready_o, busy_o}, 3'b111);
            send_beats(nm, vecs[v].n, vecs[v].gap, vecs[v].base, -1);
            if (!vecs[v].gap) chk({nm, "_throughput"}, last_acc - first_acc, vecs[v].n - 1);
            wait_ack(nm, ack0);
            check_writes(nm, vecs[v].n, vecs[v].ela, vecs[v].base);
        end

        // Missed request mid-load: load completes unchanged, flag is sticky.
        wq.delete();
        ack0 = ack_cnt;
        pulse_update(3, 1);
        send_beats("missed", 8, 0, 17'h00040, 3);
        wait_ack("missed", ack0);
        check_writes("missed", 8, 3, 17'h00040);
        chk("missed_set", missed_o, 1'b1);

        // Abort after 5 beats: fifth write still lands, no ack.
        wq.delete();
        ack0 = ack_cnt;
        pulse_update(3, 1);
        chk("missed_cleared", missed_o, 1'b0);
        send_beats("abort", 5, 0, 17'h00020, -1);
        @(negedge clk);
        abort_i   = 1'b1;
        s_valid_i = 1'b1;
        s_data_i  = 17'h00025;
        #1 chk("abort_ready_low", s_ready_o, 1'b0);
        @(posedge clk);
        #1 abort_i = 1'b0;
        s_valid_i = 1'b0;
        repeat (5) @(negedge clk);
        #1 chk("abort_idle", busy_o, 1'b0);
        chk("abort_no_ack", ack_cnt - ack0, 0);
        check_writes("abort", 5, 3, 17'h00020);

        wq.delete();
        ack0 = ack_cnt;
        pulse_update(3, 1);
        send_beats("post_abort", 8, 0, 17'h00030, -1);
        wait_ack("post_abort", ack0);
        check_writes("post_abort", 8, 3, 17'h00030);

        // Reset mid-load.
        wq.delete();
        ack0 = ack_cnt;
        pulse_update(3, 1);
        send_beats("rst_mid", 3, 0, 17'h00050, -1);
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1 chk("rst_mid_outputs",
               {11'd0, we_o, waddr_o, wdata_o, memory_selector_o, mem_updated_o,
                busy_o, missed_o, s_ready_o, load_req_o}, 32'd0);
        rst_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_no_ack", ack_cnt - ack0, 0);
        check_writes("rst_mid", 3, 3, 17'h00050);

        wq.delete();
        ack0 = ack_cnt;
        pulse_update(3, 1);
        send_beats("post_rst", 8, 0, 17'h00060, -1);
        wait_ack("post_rst", ack0);
        check_writes("post_rst", 8, 3, 17'h00060);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
